// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV64 load/store initiator: size encodings,
// FSM state enum, alignment check, byte-strobe and store-lane generation.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Natural alignment: the low address bits covered by the access size must be zero.
  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (off[0] == 1'b0);
      SZ_W:    ok = (off[1:0] == 2'b00);
      default: ok = (off == 3'b000);
    endcase
    return ok;
  endfunction

  function automatic logic [7:0] byte_strobe(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] be;
    case (size)
      SZ_B:    be = 8'h01 << off;
      SZ_H:    be = 8'h03 << off;
      SZ_W:    be = 8'h0F << off;
      default: be = 8'hFF;
    endcase
    return be;
  endfunction

  // Replicate the right-aligned store data across the dword, then move it to its lane.
  function automatic logic [63:0] store_lanes(input logic [1:0] size, input logic [2:0] off,
                                              input logic [63:0] wdata);
    logic [63:0] rep;
    case (size)
      SZ_B:    rep = {8{wdata[7:0]}};
      SZ_H:    rep = {4{wdata[15:0]}};
      SZ_W:    rep = {2{wdata[31:0]}};
      default: rep = wdata;
    endcase
    return rep << {off, 3'b000};
  endfunction

endpackage

// File: rtl/lsu_initiator_if.sv
// Pipeline request/response and data-memory port signals of the load/store initiator.
// Handshakes: req_valid/req_ready, rsp_valid/rsp_ready and mem_req/mem_gnt each transfer
// on a cycle where both are high; the initiator side holds its payload stable while
// waiting. mem_rvalid is a one-cycle completion pulse with no back-pressure.
interface lsu_initiator_if #(
    parameter int DATA_WIDTH = 64
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [2:0]                req_type;
    logic [DATA_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_WIDTH-1:0]     rsp_data;
    logic                      rsp_err;

    logic                      mem_req;
    logic                      mem_gnt;
    logic                      mem_we;
    logic [DATA_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH/8-1:0]   mem_be;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic                      mem_rvalid;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    // master: the LSU itself
    modport master (
        input  req_valid, req_we, req_type, req_addr, req_wdata,
        input  rsp_ready,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready,
        output rsp_valid, rsp_data, rsp_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    // slave: pipeline plus memory environment around the LSU
    modport slave (
        output req_valid, req_we, req_type, req_addr, req_wdata,
        output rsp_ready,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load lane extraction: shifts the raw dword down to the addressed
// byte and sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [2:0]  ltype,
    output logic [63:0] value
);
    logic [63:0] shifted;
    logic        sext;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        sext    = ~ltype[2];
        case (ltype[1:0])
            SZ_B:    value = {{56{sext & shifted[7]}},  shifted[7:0]};
            SZ_H:    value = {{48{sext & shifted[15]}}, shifted[15:0]};
            SZ_W:    value = {{32{sext & shifted[31]}}, shifted[31:0]};
            default: value = shifted;
        endcase
    end
endmodule

// File: rtl/lsu_initiator.sv
// RV64 load/store initiator: one outstanding aligned dword transaction per request.
// Optional LSU_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES in ISSUE/WAIT.
module lsu_initiator
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    lsu_initiator_if.master    bus,
    output lsu_state_e         dbg_state
);
    lsu_state_e state, state_nxt;

    logic                  we_q;
    logic [2:0]            type_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [7:0]            be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_err_q;

    logic                  accept;
    logic                  misaligned;
    logic                  complete;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] load_val;

    assign accept     = (state == ST_IDLE) && bus.req_valid;
    assign misaligned = !is_aligned(bus.req_type[1:0], bus.req_addr[2:0]);
    // A completion counts only with a grant in ISSUE or anywhere in WAIT; other rvalids are spurious.
    assign complete   = ((state == ST_ISSUE) && bus.mem_gnt && bus.mem_rvalid) ||
                        ((state == ST_WAIT) && bus.mem_rvalid);

`ifdef LSU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if ((state == ST_ISSUE) || (state == ST_WAIT)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign timeout_hit = ((state == ST_ISSUE) || (state == ST_WAIT)) &&
                         (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) && !complete;
`else
    assign timeout_hit = 1'b0;
`endif

    lsu_load_align u_align (
        .rdata  (bus.mem_rdata),
        .offset (addr_q[2:0]),
        .ltype  (type_q),
        .value  (load_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) state_nxt = misaligned ? ST_RESP : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (complete || timeout_hit) state_nxt = ST_RESP;
                else if (bus.mem_gnt)        state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (complete || timeout_hit) state_nxt = ST_RESP;
            end
            default: begin
                if (bus.rsp_ready) state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request capture; strobes and lane data are computed once here so the memory port stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            type_q  <= 3'b000;
            addr_q  <= '0;
            be_q    <= 8'h00;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            type_q  <= bus.req_type;
            addr_q  <= bus.req_addr;
            be_q    <= byte_strobe(bus.req_type[1:0], bus.req_addr[2:0]);
            wdata_q <= store_lanes(bus.req_type[1:0], bus.req_addr[2:0], bus.req_wdata);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (accept && misaligned) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
        end else if (complete) begin
            rsp_data_q <= we_q ? '0 : load_val;
            rsp_err_q  <= 1'b0;
        end else if (timeout_hit) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_req   = (state == ST_ISSUE);
    assign bus.mem_we    = (state == ST_ISSUE) && we_q;
    assign bus.mem_addr  = {addr_q[DATA_WIDTH-1:3], 3'b000};
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;
    assign dbg_state     = state;

endmodule
